// File: rtl/pwm_pkg.sv
// Shared types and default parameters for the fixed-duty PWM generator.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HIGH = 2'b01,
    LOW  = 2'b10
  } state_e;

  localparam int CNT_W_DEF       = 26;
  localparam int PERIOD_DEF      = 20;
  localparam int HIGH_CYCLES_DEF = 5;

endpackage

// File: rtl/pwm_fsm.sv
// Fixed-duty PWM generator: 2-bit Moore FSM plus a period counter, clocked by a 1 ms tick.
// Define PWM_INVERT_EN to make the PWM pin active-low (high everywhere except in HIGH).
module pwm_fsm
  import pwm_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int PERIOD      = PERIOD_DEF,
  parameter int HIGH_CYCLES = HIGH_CYCLES_DEF
) (
  input  logic             clk1ms,
  input  logic             reset,
  output logic             PWM,
  output logic [1:0]       nextState,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] counter
);

  if (PERIOD < 2 || longint'(PERIOD) > (longint'(1) << CNT_W)) begin : g_bad_period
    $error("pwm_fsm: PERIOD %0d outside 2..2**CNT_W", PERIOD);
  end
  if (HIGH_CYCLES < 0 || HIGH_CYCLES > PERIOD) begin : g_bad_high
    $error("pwm_fsm: HIGH_CYCLES %0d outside 0..PERIOD", HIGH_CYCLES);
  end

  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] HIGH_LAST   = CNT_W'((HIGH_CYCLES > 0) ? HIGH_CYCLES - 1 : 0);
  localparam bit               NO_HIGH     = (HIGH_CYCLES == 0);
  localparam bit               ALL_HIGH    = (HIGH_CYCLES == PERIOD);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic             high_phase;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk1ms or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk1ms or negedge reset) begin
    if (!reset) counter_q <= '0;
    else        counter_q <= counter_d;
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_d    = IDLE;
    counter_d  = '0;
    high_phase = 1'b0;
    unique case (state_q)
      IDLE: state_d = NO_HIGH ? LOW : HIGH;
      HIGH: begin
        high_phase = 1'b1;
        counter_d  = counter_q + CNT_W'(1);
        state_d    = HIGH;
        if (ALL_HIGH) begin
          if (counter_q == PERIOD_LAST) counter_d = '0;
        end else if (counter_q == HIGH_LAST) begin
          state_d = LOW;
        end
      end
      LOW: begin
        counter_d = counter_q + CNT_W'(1);
        state_d   = LOW;
        if (counter_q == PERIOD_LAST) begin
          counter_d = '0;
          if (!NO_HIGH) state_d = HIGH;
        end
      end
      default: ; // illegal 2'b11 recovers to IDLE with the counter cleared
    endcase
  end

  assign state     = state_q;
  assign nextState = state_d;
  assign counter   = counter_q;

`ifdef PWM_INVERT_EN
  assign PWM = ~high_phase;
`else
  assign PWM = high_phase;
`endif

endmodule

// File: tb/tb_pwm_fsm.sv
// Self-checking bench for pwm_fsm: four parameterisations share clock and reset and are
// compared every cycle against a period-position model, with random async reset pulses.
module tb_pwm_fsm;
  import pwm_pkg::*;

  localparam int N = 4;
  localparam int P_TAB [N] = '{20, 20, 20, 16};
  localparam int H_TAB [N] = '{5, 0, 20, 3};
`ifdef PWM_INVERT_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  logic        clk1ms = 1'b0;
  logic        reset  = 1'b0;
  logic        pw [N];
  logic [1:0]  st [N];
  logic [1:0]  ns [N];
  logic [25:0] cn [N];
  logic [3:0]  cn_edge;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: idle flag plus position within the period (position 0 = first cycle after IDLE).
  bit idle_m [N];
  int pos_m  [N];

  always #5 clk1ms = ~clk1ms;

  pwm_fsm u_def (.clk1ms(clk1ms), .reset(reset), .PWM(pw[0]), .nextState(ns[0]),
                 .state(st[0]), .counter(cn[0]));
  pwm_fsm #(.CNT_W(26), .PERIOD(20), .HIGH_CYCLES(0)) u_zero (
    .clk1ms(clk1ms), .reset(reset), .PWM(pw[1]), .nextState(ns[1]), .state(st[1]), .counter(cn[1]));
  pwm_fsm #(.CNT_W(26), .PERIOD(20), .HIGH_CYCLES(20)) u_full (
    .clk1ms(clk1ms), .reset(reset), .PWM(pw[2]), .nextState(ns[2]), .state(st[2]), .counter(cn[2]));
  pwm_fsm #(.CNT_W(4), .PERIOD(16), .HIGH_CYCLES(3)) u_edge (
    .clk1ms(clk1ms), .reset(reset), .PWM(pw[3]), .nextState(ns[3]), .state(st[3]), .counter(cn_edge));
  assign cn[3] = {22'd0, cn_edge};

  function automatic logic [1:0] phase_of(int k, int pos);
    return (pos < H_TAB[k]) ? 2'b01 : 2'b10;
  endfunction

  // Expected {state, nextState, counter, PWM} for instance k.
  function automatic logic [30:0] exp_tuple(int k);
    logic [1:0] s, n;
    int c;
    if (idle_m[k]) begin
      s = 2'b00;
      n = (H_TAB[k] > 0) ? 2'b01 : 2'b10;
      c = 0;
    end else begin
      s = phase_of(k, pos_m[k]);
      n = phase_of(k, (pos_m[k] + 1) % P_TAB[k]);
      c = pos_m[k];
    end
    return {s, n, 26'(c), (s == 2'b01) ^ INV};
  endfunction

  function automatic logic [30:0] obs_tuple(int k);
    return {st[k], ns[k], cn[k], pw[k]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      idle_m[k] = 1'b1;
      pos_m[k]  = 0;
    end
  endtask

  // One clock: update the model on the rising edge, land on the falling edge for sampling.
  task automatic advance();
    @(posedge clk1ms);
    if (reset) begin
      for (int k = 0; k < N; k++) begin
        if (idle_m[k]) begin
          idle_m[k] = 1'b0;
          pos_m[k]  = 0;
        end else begin
          pos_m[k] = (pos_m[k] + 1) % P_TAB[k];
        end
      end
    end
    @(negedge clk1ms);
  endtask

  task automatic test_reset();
    model_reset();
    #3;
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if (obs_tuple(k) !== exp_tuple(k)) begin
        n_fail++;
        $display("FAIL reset_t3 inst%0d got %h expected %h", k, obs_tuple(k), exp_tuple(k));
      end
    end
    for (int cyc = 0; cyc < 4; cyc++) begin
      advance();
      for (int k = 0; k < N; k++) begin
        n_checks++;
        if (obs_tuple(k) !== exp_tuple(k)) begin
          n_fail++;
          $display("FAIL reset_hold inst%0d cyc%0d got %h expected %h", k, cyc, obs_tuple(k), exp_tuple(k));
        end
      end
    end
  endtask

  task automatic test_periods();
    int highs;
    highs = 0;
    #2 reset = 1'b1;
    for (int cyc = 0; cyc < 45; cyc++) begin
      advance();
      if (cyc < 20 && (pw[0] ^ INV)) highs++;
      for (int k = 0; k < N; k++) begin
        n_checks++;
        if (obs_tuple(k) !== exp_tuple(k)) begin
          n_fail++;
          $display("FAIL periods inst%0d cyc%0d got %h expected %h", k, cyc, obs_tuple(k), exp_tuple(k));
        end
      end
    end
    n_checks++;
    if (highs !== 5) begin
      n_fail++;
      $display("FAIL duty_first_period got %0d high cycles expected 5", highs);
    end
  endtask

  task automatic test_reset_mid_high();
    int budget;
    int highs;
    budget = 0;
    while (!(pos_m[0] == 3 && !idle_m[0]) && budget < 40) begin
      advance();
      budget++;
    end
    n_checks++;
    if (budget >= 40) begin
      n_fail++;
      $display("FAIL mid_high_wait got timeout expected counter 3 within 40 cycles");
    end
    #2 reset = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if (obs_tuple(k) !== exp_tuple(k)) begin
        n_fail++;
        $display("FAIL mid_reset_async inst%0d got %h expected %h", k, obs_tuple(k), exp_tuple(k));
      end
    end
    @(negedge clk1ms);
    #2 reset = 1'b1;
    highs = 0;
    for (int cyc = 0; cyc < 25; cyc++) begin
      advance();
      if (cyc < 20 && (pw[0] ^ INV)) highs++;
      for (int k = 0; k < N; k++) begin
        n_checks++;
        if (obs_tuple(k) !== exp_tuple(k)) begin
          n_fail++;
          $display("FAIL after_mid_reset inst%0d cyc%0d got %h expected %h", k, cyc, obs_tuple(k), exp_tuple(k));
        end
      end
    end
    n_checks++;
    if (highs !== 5) begin
      n_fail++;
      $display("FAIL duty_after_reset got %0d high cycles expected 5", highs);
    end
  endtask

  task automatic test_random_resets();
    int run_len;
    int hold;
    for (int it = 0; it < 12; it++) begin
      run_len = $urandom_range(1, 50);
      for (int cyc = 0; cyc < run_len; cyc++) begin
        advance();
        for (int k = 0; k < N; k++) begin
          n_checks++;
          if (obs_tuple(k) !== exp_tuple(k)) begin
            n_fail++;
            $display("FAIL random_run it%0d inst%0d got %h expected %h", it, k, obs_tuple(k), exp_tuple(k));
          end
        end
      end
      #($urandom_range(1, 3)) reset = 1'b0;
      model_reset();
      #1;
      for (int k = 0; k < N; k++) begin
        n_checks++;
        if (obs_tuple(k) !== exp_tuple(k)) begin
          n_fail++;
          $display("FAIL random_reset it%0d inst%0d got %h expected %h", it, k, obs_tuple(k), exp_tuple(k));
        end
      end
      @(negedge clk1ms);
      hold = $urandom_range(0, 2);
      for (int cyc = 0; cyc < hold; cyc++) begin
        advance();
        for (int k = 0; k < N; k++) begin
          n_checks++;
          if (obs_tuple(k) !== exp_tuple(k)) begin
            n_fail++;
            $display("FAIL random_hold it%0d inst%0d got %h expected %h", it, k, obs_tuple(k), exp_tuple(k));
          end
        end
      end
      #2 reset = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_periods();
    test_reset_mid_high();
    test_random_resets();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
